alu_share_ctrl: RTL



---
 rtl/alu_share_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Shared 64-bit Y86 ALU: round-robin arbiter over two requesters, a three-state
// IDLE/EXEC/RESP sequencer, a registered response bus and the ZF/SF/OF flags.

module alu_share_alu (
  input  logic [3:0]  fun,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        err,
  output logic        zf,
  output logic        sf,
  output logic        of
);
  always_comb begin
    result = '0;
    err    = 1'b0;
    of     = 1'b0;
    case (fun)
      4'd0: begin
        result = a + b;
        of     = (a[63] == b[63]) && (result[63] != a[63]);
      end
      // Y86 subq computes valB - valA
      4'd1: begin
        result = b - a;
        of     = (a[63] != b[63]) && (result[63] != b[63]);
      end
      4'd2:    result = a & b;
      4'd3:    result = a ^ b;
      default: err = 1'b1;
    endcase
    zf = (result == 64'd0);
    sf = result[63];
  end
endmodule

module alu_share_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_fun,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req0_setcc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_fun,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic        req1_setcc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_result,
  output logic        resp_err,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  fun;
    logic [63:0] a;
    logic [63:0] b;
    logic        setcc;
    logic        id;
  } req_t;

  state_t      state, state_nxt;
  req_t        cur;
  logic        rr_ptr;
  logic        grant0, grant1, fire;
  logic [63:0] alu_result;
  logic        alu_err, alu_zf, alu_sf, alu_of;

  alu_share_alu u_alu (
    .fun    (cur.fun),
    .a      (cur.a),
    .b      (cur.b),
    .result (alu_result),
    .err    (alu_err),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // rr_ptr only breaks ties; a lone valid port always wins
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !rr_ptr);
    grant1     = req1_valid && (!req0_valid || rr_ptr);
    req0_ready = rst_n && (state == IDLE) && grant0;
    req1_ready = rst_n && (state == IDLE) && grant1;
    fire       = req0_ready || req1_ready;
    state_nxt  = state;
    case (state)
      IDLE:    if (fire) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= '0;
      rr_ptr      <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      cc_zf       <= 1'b1;
      cc_sf       <= 1'b0;
      cc_of       <= 1'b0;
    end else begin
      if (fire) begin
        cur    <= grant0 ? {req0_fun, req0_a, req0_b, req0_setcc, 1'b0}
                         : {req1_fun, req1_a, req1_b, req1_setcc, 1'b1};
        rr_ptr <= grant0;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_err    <= alu_err;
        resp_id     <= cur.id;
        if (cur.setcc && !alu_err) begin
          cc_zf <= alu_zf;
          cc_sf <= alu_sf;
          cc_of <= alu_of;
        end
      end
    end
  end
endmodule
